cic_region_sequencer: RTL and testbench

- Sequences the CIC lock core and the console region output: holds off CIC start after boot, monitors CIC failure, toggles PAL/NTSC and retries, and locks out after too many failures.
- Replaces ad-hoc region toggle and delay logic in the top level.
- Sits between the top-level reset/IGR signals and cic_lock_top: drives its enable and pal_ntsc inputs, and gates system reset.

---
 rtl/cic_region_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cic_region_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_region_sequencer.sv
// CIC enable / PAL-NTSC region sequencer with retry and lockout.
// Optional CIC_FAIL_FILTER_EN: require 8 consecutive high cic_fail samples.
module cic_region_sequencer #(
  parameter int LOCK_DELAY  = 32767,
  parameter int FAIL_HOLD   = 1024,
  parameter int MAX_RETRIES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       CLK_i,
  input  logic       NRST_i,
  input  logic       RESETI_i,
  input  logic       REQ_RST_i,
  input  logic       CIC_FAIL_i,
  input  logic       FORCE_REGION_i,
  input  logic       FORCE_PAL_i,
  output logic       CIC_EN_o,
  output logic       PAL_NTSC_o,
  output logic       SYS_HOLD_o,
  output logic       LOCKOUT_o,
  output logic [2:0] STATE_o,
  output logic [3:0] RETRY_CNT_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RUN  = 3'd2,
    S_FAIL = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  state_t           st, nst;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [3:0]       rc, nrc;
  logic             pal, npal;
  logic             rs1, rs2;
  logic             restart;
  logic             fail_cur, fail_q, fail_edge;

  assign restart   = rs2 | REQ_RST_i;
  assign fail_edge = fail_cur & ~fail_q;

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      rs1 <= 1'b0;
      rs2 <= 1'b0;
    end else begin
      rs1 <= RESETI_i;
      rs2 <= rs1;
    end
  end

`ifdef CIC_FAIL_FILTER_EN
  logic [2:0] fcnt;

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      fcnt <= 3'd0;
    end else if (restart || !CIC_FAIL_i) begin
      fcnt <= 3'd0;
    end else if (fcnt != 3'd7) begin
      fcnt <= fcnt + 3'd1;
    end
  end

  // Seven prior highs plus the current one make eight.
  assign fail_cur = CIC_FAIL_i && (fcnt == 3'd7);
`else
  assign fail_cur = CIC_FAIL_i;
`endif

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_cur;
    end
  end

  always_comb begin
    nst  = st;
    ncnt = cnt;
    nrc  = rc;
    npal = pal;
    if (restart) begin
      nst  = S_IDLE;
      ncnt = '0;
      nrc  = 4'd0;
      if (FORCE_REGION_i) npal = FORCE_PAL_i;
    end else begin
      case (st)
        S_IDLE: begin
          nst  = S_WAIT;
          ncnt = '0;
        end
        S_WAIT: begin
          if (cnt == CNT_W'(LOCK_DELAY - 1)) begin
            nst  = S_RUN;
            ncnt = '0;
          end else begin
            ncnt = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (fail_edge) begin
            nst  = S_FAIL;
            ncnt = '0;
            nrc  = (rc == 4'd15) ? rc : rc + 4'd1;
          end else if (FORCE_REGION_i && (FORCE_PAL_i != pal)) begin
            nst  = S_WAIT;
            ncnt = '0;
            npal = FORCE_PAL_i;
          end
        end
        S_FAIL: begin
          if (cnt == CNT_W'(FAIL_HOLD - 1)) begin
            ncnt = '0;
            if (rc >= 4'(MAX_RETRIES)) begin
              nst = S_LOCK;
            end else begin
              nst  = S_WAIT;
              npal = FORCE_REGION_i ? FORCE_PAL_i : ~pal;
            end
          end else begin
            ncnt = cnt + CNT_W'(1);
          end
        end
        S_LOCK: begin
          nst = S_LOCK;
        end
        default: begin
          nst  = S_IDLE;
          ncnt = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they move with STATE_o.
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      st         <= S_IDLE;
      cnt        <= '0;
      rc         <= 4'd0;
      pal        <= 1'b0;
      CIC_EN_o   <= 1'b0;
      SYS_HOLD_o <= 1'b1;
      LOCKOUT_o  <= 1'b0;
    end else begin
      st         <= nst;
      cnt        <= ncnt;
      rc         <= nrc;
      pal        <= npal;
      CIC_EN_o   <= (nst == S_RUN);
      SYS_HOLD_o <= (nst != S_RUN);
      LOCKOUT_o  <= (nst == S_LOCK);
    end
  end

  assign STATE_o     = st;
  assign RETRY_CNT_o = rc;
  assign PAL_NTSC_o  = pal;

endmodule

// File: tb/tb_cic_region_sequencer.sv
// Table-driven bench for cic_region_sequencer.
// LOCK_DELAY=16, FAIL_HOLD=4, MAX_RETRIES=3.
module tb_cic_region_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rsti = 1'b0;
  logic       req = 1'b0;
  logic       fail = 1'b0;
  logic       frg = 1'b0;
  logic       fpal = 1'b0;
  logic       cic_en, pal_ntsc, sys_hold, lockout;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  cic_region_sequencer #(
    .LOCK_DELAY(16),
    .FAIL_HOLD(4),
    .MAX_RETRIES(3),
    .CNT_W(16)
  ) dut (
    .CLK_i(clk),
    .NRST_i(rst_n),
    .RESETI_i(rsti),
    .REQ_RST_i(req),
    .CIC_FAIL_i(fail),
    .FORCE_REGION_i(frg),
    .FORCE_PAL_i(fpal),
    .CIC_EN_o(cic_en),
    .PAL_NTSC_o(pal_ntsc),
    .SYS_HOLD_o(sys_hold),
    .LOCKOUT_o(lockout),
    .STATE_o(state),
    .RETRY_CNT_o(retry_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       pal;
    logic       hold;
    logic       lock;
    logic [3:0] rc;
  } out_t;

  typedef struct {
    logic req;
    logic rsti;
    logic fail;
    logic frg;
    logic fpal;
    int   n;
    out_t want;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk(int st, bit p, int rc);
    out_t o;
    o.st   = 3'(st);
    o.en   = (st == 2);
    o.pal  = p;
    o.hold = (st != 2);
    o.lock = (st == 4);
    o.rc   = 4'(rc);
    return o;
  endfunction

  function automatic void add(bit rq, bit rs, bit f, bit fr, bit fp,
                              int n, int st, bit p, int rc);
    vec_t t;
    t.req  = rq;
    t.rsti = rs;
    t.fail = f;
    t.frg  = fr;
    t.fpal = fp;
    t.n    = n;
    t.want = mk(st, p, rc);
    tbl.push_back(t);
  endfunction

  task automatic check(string name, out_t e);
    out_t a;
    a = {state, cic_en, pal_ntsc, sys_hold, lockout, retry_cnt};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d en=%b pal=%b hold=%b lock=%b rc=%0d want st=%0d en=%b pal=%b hold=%b lock=%b rc=%0d",
               name, a.st, a.en, a.pal, a.hold, a.lock, a.rc,
               e.st, e.en, e.pal, e.hold, e.lock, e.rc);
    end
  endtask

  initial begin
    int cyc;
`ifdef CIC_FAIL_FILTER_EN
    add(0,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,0,15, 1,0,0);
    add(0,0,0,0,0, 1, 2,0,0);
    add(0,0,1,0,0, 7, 2,0,0);
    add(0,0,0,0,0, 1, 2,0,0);
    add(0,0,1,0,0, 7, 2,0,0);
    add(0,0,1,0,0, 1, 3,0,1);
    add(0,0,0,0,0, 4, 1,1,1);
    add(0,0,0,0,0,16, 2,1,1);
`else
    add(0,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,0,15, 1,0,0);
    add(0,0,0,0,0, 1, 2,0,0);
    add(0,0,1,0,0, 1, 3,0,1);
    add(0,0,0,0,0, 3, 3,0,1);
    add(0,0,0,0,0, 1, 1,1,1);
    add(0,0,0,0,0,15, 1,1,1);
    add(0,0,0,0,0, 1, 2,1,1);
    add(0,0,1,0,0, 1, 3,1,2);
    add(0,0,0,0,0, 4, 1,0,2);
    add(0,0,0,0,0,16, 2,0,2);
    add(0,0,1,0,0, 1, 3,0,3);
    add(0,0,0,0,0, 3, 3,0,3);
    add(0,0,0,0,0, 1, 4,0,3);
    add(0,0,1,0,0, 1, 4,0,3);
    add(0,0,0,0,0, 5, 4,0,3);
    add(1,0,0,0,0, 1, 0,0,0);
    add(0,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,0,15, 1,0,0);
    add(0,0,0,0,0, 1, 2,0,0);
    add(0,0,0,1,1, 1, 1,1,0);
    add(0,0,0,1,1,16, 2,1,0);
    add(0,0,1,1,1, 1, 3,1,1);
    add(0,0,0,1,1, 4, 1,1,1);
    add(0,0,0,1,1,16, 2,1,1);
    add(0,0,1,1,0, 1, 3,1,2);
    add(0,0,0,1,0, 4, 1,0,2);
    add(0,0,0,1,0,16, 2,0,2);
    add(0,1,0,0,0, 1, 2,0,2);
    add(0,1,0,0,0, 1, 2,0,2);
    add(0,1,0,1,1, 1, 0,1,0);
    add(0,1,0,0,0, 8, 0,1,0);
    add(0,0,0,0,0, 1, 0,1,0);
    add(0,0,0,0,0, 1, 0,1,0);
    add(0,0,0,0,0, 1, 1,1,0);
    add(0,0,1,0,0,15, 1,1,0);
    add(0,0,1,0,0, 1, 2,1,0);
    add(0,0,1,0,0, 3, 2,1,0);
    add(0,0,0,0,0, 1, 2,1,0);
    add(0,0,1,0,0, 1, 3,1,1);
    add(0,0,0,0,0, 4, 1,0,1);
    add(0,0,0,0,0,16, 2,0,1);
    add(1,0,1,0,0, 1, 0,0,0);
    add(0,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,0, 5, 1,0,0);
    add(1,0,0,0,0, 1, 0,0,0);
    add(0,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,0,15, 1,0,0);
    add(0,0,0,0,0, 1, 2,0,0);
`endif

    #12;
    check("reset", mk(0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      rsti = tbl[i].rsti;
      fail = tbl[i].fail;
      frg  = tbl[i].frg;
      fpal = tbl[i].fpal;
      sb.push_back(tbl[i].want);
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), sb.pop_front());
    end

    // Restart pulse: IDLE edge, then 16 WAIT cycles, then RUN.
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("req_idle", mk(0, pal_ntsc, 0));
    cyc = 0;
    while (state != 3'd2 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 17) begin
      n_bad++;
      $display("FAIL restart_latency: got %0d cycles want 17", cyc);
    end

    // Asynchronous reset mid-RUN.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
